normalize_shift_seq: RTL and testbench

Iterative, parametrised leading-one normaliser for the FPU datapath. It left-shifts an unsigned fraction until its MSB is '1', shifting at most STEP bits per clock, and adjusts an accompanying biased exponent by the total shift. An optional denormal clamp stops shifting when the exponent would fall below 1. Valid/ready handshakes on both sides let it sit between the add/sub alignment stage and the rounding stage, and allow it to stall.

---
 rtl/normalize_shift_seq.sv | 196 +++++++++++++++++++
 tb/tb_normalize_shift_seq.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/normalize_shift_seq.sv
// Iterative leading-one normaliser: shifts a fraction left by up to STEP
// bits per cycle and adjusts its biased exponent, with an optional denormal clamp.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   operand handshake (frac_in, exp_in)
//   flush               synchronous abort, wins over accept/retire
//   out_valid/out_ready result handshake
//   frac_out, exp_out   normalised fraction and adjusted exponent
//   shift_amt           total left shift applied
//   zero                input fraction was zero
//   denorm              clamp stopped shifting before MSB reached (CLAMP=1)
//   underflow           total shift exceeded exp_in (CLAMP=0)
module normalize_shift_seq #(
    parameter int WIDTH = 26,
    parameter int STEP  = 4,
    parameter int EXP_W = 8,
    parameter int CLAMP = 1,
    parameter int SHW   = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] frac_in,
    input  logic [EXP_W-1:0] exp_in,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] frac_out,
    output logic [EXP_W-1:0] exp_out,
    output logic [SHW-1:0]   shift_amt,
    output logic             zero,
    output logic             denorm,
    output logic             underflow
);

    // Common width for comparing exponent-sized and shift-sized quantities.
    localparam int HW = (EXP_W > SHW) ? EXP_W : SHW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    // Working registers
    logic [WIDTH-1:0] frac_q, frac_d;
    logic [EXP_W-1:0] exp_q, exp_d;
    logic [SHW-1:0]   amt_q, amt_d;
    logic [EXP_W-1:0] head_q, head_d;
    logic [EXP_W-1:0] expin_q, expin_d;

    // Result registers, only written on SHIFT->DONE
    logic [WIDTH-1:0] fo_q, fo_d;
    logic [EXP_W-1:0] eo_q, eo_d;
    logic [SHW-1:0]   sa_q, sa_d;
    logic             zero_q, zero_d;
    logic             den_q, den_d;
    logic             unf_q, unf_d;

    // Per-cycle shift evaluation
    logic [SHW-1:0]   lz_k;
    logic             lz_found;
    logic [SHW-1:0]   step_s;
    logic             is_zero;
    logic             is_norm;
    logic             at_limit;
    logic             finish;
    logic             unf_now;

    // Leading zeros within the top STEP bits; STEP when all are zero.
    always_comb begin
        lz_k     = SHW'(STEP);
        lz_found = 1'b0;
        for (int i = 0; i < STEP; i++) begin
            if (!lz_found && frac_q[WIDTH-1-i]) begin
                lz_k     = SHW'(i);
                lz_found = 1'b1;
            end
        end
    end

    always_comb begin
        is_zero  = (frac_q == '0);
        is_norm  = frac_q[WIDTH-1];
        at_limit = (CLAMP != 0) && (head_q == '0);
        finish   = is_zero || is_norm || at_limit;
        // Clamp the step to the remaining exponent headroom; headroom < k
        // means it is below STEP, so it fits the shift-amount width.
        if ((CLAMP != 0) && (HW'(head_q) < HW'(lz_k))) begin
            step_s = SHW'(head_q);
        end else begin
            step_s = lz_k;
        end
        unf_now = (CLAMP == 0) && (HW'(amt_q) > HW'(expin_q));
    end

    always_comb begin
        state_d = state_q;
        frac_d  = frac_q;
        exp_d   = exp_q;
        amt_d   = amt_q;
        head_d  = head_q;
        expin_d = expin_q;
        fo_d    = fo_q;
        eo_d    = eo_q;
        sa_d    = sa_q;
        zero_d  = zero_q;
        den_d   = den_q;
        unf_d   = unf_q;

        if (flush) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        frac_d  = frac_in;
                        exp_d   = exp_in;
                        expin_d = exp_in;
                        amt_d   = '0;
                        head_d  = (exp_in == '0) ? '0 : exp_in - 1'b1;
                        state_d = S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (finish) begin
                        fo_d    = frac_q;
                        eo_d    = exp_q;
                        sa_d    = amt_q;
                        zero_d  = is_zero;
                        den_d   = !is_zero && !is_norm && at_limit;
                        unf_d   = unf_now;
                        state_d = S_DONE;
                    end else begin
                        frac_d = frac_q << step_s;
                        exp_d  = exp_q - EXP_W'(step_s);
                        amt_d  = amt_q + step_s;
                        head_d = head_q - EXP_W'(step_s);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            frac_q  <= '0;
            exp_q   <= '0;
            amt_q   <= '0;
            head_q  <= '0;
            expin_q <= '0;
            fo_q    <= '0;
            eo_q    <= '0;
            sa_q    <= '0;
            zero_q  <= 1'b0;
            den_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            frac_q  <= frac_d;
            exp_q   <= exp_d;
            amt_q   <= amt_d;
            head_q  <= head_d;
            expin_q <= expin_d;
            fo_q    <= fo_d;
            eo_q    <= eo_d;
            sa_q    <= sa_d;
            zero_q  <= zero_d;
            den_q   <= den_d;
            unf_q   <= unf_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign frac_out  = fo_q;
    assign exp_out   = eo_q;
    assign shift_amt = sa_q;
    assign zero      = zero_q;
    assign denorm    = den_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_normalize_shift_seq.sv
// Scoreboard bench for normalize_shift_seq: three instances
// (STEP=4/CLAMP=1, STEP=1/CLAMP=1, STEP=4/CLAMP=0) with directed vectors.
module tb_normalize_shift_seq;

    typedef struct {
        logic [25:0] frac;
        logic [7:0]  ex;
        logic [4:0]  sa;
        logic        z;
        logic        d;
        logic        u;
        int          lat;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid  [3];
    logic        in_ready  [3];
    logic [25:0] frac_in   [3];
    logic [7:0]  exp_in    [3];
    logic        flush     [3];
    logic        out_valid [3];
    logic        out_ready [3];
    logic [25:0] frac_out  [3];
    logic [7:0]  exp_out   [3];
    logic [4:0]  shift_amt [3];
    logic        zero      [3];
    logic        denorm    [3];
    logic        underflow [3];

    exp_t sbq [3][$];
    bit   seen [3];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : gd
        normalize_shift_seq #(
            .WIDTH(26),
            .STEP (g == 1 ? 1 : 4),
            .EXP_W(8),
            .CLAMP(g == 2 ? 0 : 1)
        ) dut (
            .clk      (clk),
            .rst      (rst),
            .in_valid (in_valid[g]),
            .in_ready (in_ready[g]),
            .frac_in  (frac_in[g]),
            .exp_in   (exp_in[g]),
            .flush    (flush[g]),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .frac_out (frac_out[g]),
            .exp_out  (exp_out[g]),
            .shift_amt(shift_amt[g]),
            .zero     (zero[g]),
            .denorm   (denorm[g]),
            .underflow(underflow[g])
        );
    end

    task automatic chk(input string nm, input int g,
                       input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s dut%0d actual=%0h required=%0h", nm, g, act, req);
        end
    endtask

    function automatic logic [63:0] pack_out(input int g);
        return {22'd0, frac_out[g], exp_out[g], shift_amt[g],
                zero[g], denorm[g], underflow[g]};
    endfunction

    // Monitor: compare every cycle a result is presented, pop on retire.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int g = 0; g < 3; g++) begin
                    if (out_valid[g]) begin
                        if (sbq[g].size() == 0) begin
                            chk("spurious_valid", g, 64'(out_valid[g]), 64'd0);
                        end else begin
                            e = sbq[g][0];
                            if (!seen[g]) begin
                                chk("latency", g, 64'(cyc - e.acc), 64'(e.lat));
                                seen[g] = 1'b1;
                            end
                            chk("result", g, pack_out(g),
                                {22'd0, e.frac, e.ex, e.sa, e.z, e.d, e.u});
                            chk("in_ready_busy", g, 64'(in_ready[g]), 64'd0);
                            if (out_ready[g]) begin
                                sbq[g].delete(0);
                                seen[g] = 1'b0;
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic issue(input int g, input logic [25:0] f, input logic [7:0] e,
                         input bit push, input logic [25:0] xf, input logic [7:0] xe,
                         input logic [4:0] xs, input bit xz, input bit xd,
                         input bit xu, input int xl);
        exp_t x;
        int n = 0;
        while (!in_ready[g] && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready[g]) chk("accept_timeout", g, 64'(in_ready[g]), 64'd1);
        in_valid[g] = 1'b1;
        frac_in[g]  = f;
        exp_in[g]   = e;
        if (push) begin
            x.frac = xf; x.ex = xe; x.sa = xs;
            x.z = xz; x.d = xd; x.u = xu;
            x.lat = xl; x.acc = cyc;
            sbq[g].push_back(x);
        end
        @(posedge clk); #1;
        in_valid[g] = 1'b0;
    endtask

    task automatic drain(input int g);
        int n = 0;
        while ((sbq[g].size() != 0 || !in_ready[g]) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (sbq[g].size() != 0) chk("drain_timeout", g, 64'(sbq[g].size()), 64'd0);
    endtask

    task automatic chk_reset_state(input string nm, input int g);
        chk({nm, "_outs"}, g, pack_out(g), 64'd0);
        chk({nm, "_in_ready"}, g, 64'(in_ready[g]), 64'd1);
        chk({nm, "_out_valid"}, g, 64'(out_valid[g]), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        for (int g = 0; g < 3; g++) begin
            in_valid[g] = 1'b0; frac_in[g] = '0; exp_in[g] = '0;
            flush[g] = 1'b0; out_ready[g] = 1'b1; seen[g] = 1'b0;
        end
        #12;
        for (int g = 0; g < 3; g++) chk_reset_state("reset", g);
        @(posedge clk); #1;
        rst = 1'b0;

        // STEP=4, CLAMP=1
        issue(0, 26'h2000000, 8'd100, 1, 26'h2000000, 8'd100, 5'd0, 0, 0, 0, 2);
        drain(0);
        issue(0, 26'h0100000, 8'd100, 1, 26'h2000000, 8'd95, 5'd5, 0, 0, 0, 4);
        drain(0);
        issue(0, 26'h0000001, 8'd127, 1, 26'h2000000, 8'd102, 5'd25, 0, 0, 0, 9);
        drain(0);
        issue(0, 26'h0100000, 8'd3, 1, 26'h0400000, 8'd1, 5'd2, 0, 1, 0, 3);
        drain(0);
        issue(0, 26'h0000000, 8'd50, 1, 26'h0000000, 8'd50, 5'd0, 1, 0, 0, 2);
        drain(0);
        issue(0, 26'h0100000, 8'd0, 1, 26'h0100000, 8'd0, 5'd0, 0, 1, 0, 2);
        drain(0);
        issue(0, 26'h0100000, 8'd1, 1, 26'h0100000, 8'd1, 5'd0, 0, 1, 0, 2);
        drain(0);
        issue(0, 26'h2000000, 8'd0, 1, 26'h2000000, 8'd0, 5'd0, 0, 0, 0, 2);
        drain(0);
        issue(0, 26'h0100000, 8'd6, 1, 26'h2000000, 8'd1, 5'd5, 0, 0, 0, 4);
        drain(0);

        // Stall in DONE for 5 cycles
        out_ready[0] = 1'b0;
        issue(0, 26'h0100000, 8'd100, 1, 26'h2000000, 8'd95, 5'd5, 0, 0, 0, 4);
        repeat (8) begin @(posedge clk); #1; end
        out_ready[0] = 1'b1;
        drain(0);

        // Flush mid-SHIFT: result must never appear
        issue(0, 26'h0000001, 8'd127, 0, '0, '0, '0, 0, 0, 0, 0);
        @(posedge clk); #1;
        flush[0] = 1'b1;
        @(posedge clk); #1;
        flush[0] = 1'b0;
        chk("flush_in_ready", 0, 64'(in_ready[0]), 64'd1);
        chk("flush_out_valid", 0, 64'(out_valid[0]), 64'd0);
        repeat (15) begin @(posedge clk); #1; end
        issue(0, 26'h0100000, 8'd100, 1, 26'h2000000, 8'd95, 5'd5, 0, 0, 0, 4);
        drain(0);

        // STEP=1
        issue(1, 26'h0000001, 8'd127, 1, 26'h2000000, 8'd102, 5'd25, 0, 0, 0, 27);
        drain(1);
        issue(1, 26'h0100000, 8'd100, 1, 26'h2000000, 8'd95, 5'd5, 0, 0, 0, 7);
        drain(1);

        // CLAMP=0
        issue(2, 26'h0100000, 8'd3, 1, 26'h2000000, 8'hFE, 5'd5, 0, 0, 1, 4);
        drain(2);
        issue(2, 26'h0100000, 8'd5, 1, 26'h2000000, 8'd0, 5'd5, 0, 0, 0, 4);
        drain(2);
        issue(2, 26'h0000001, 8'd0, 1, 26'h2000000, 8'hE7, 5'd25, 0, 0, 1, 9);
        drain(2);

        // Reset mid-SHIFT
        issue(0, 26'h0000001, 8'd127, 0, '0, '0, '0, 0, 0, 0, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk_reset_state("midreset", 0);
        @(posedge clk); #1;
        rst = 1'b0;
        issue(0, 26'h0100000, 8'd100, 1, 26'h2000000, 8'd95, 5'd5, 0, 0, 0, 4);
        drain(0);

        repeat (3) begin @(posedge clk); #1; end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
